// File: rtl/simd_pkg.sv
// Shared types and defaults for the SIMD vector ALU.
// Build option: define SIMD_VEC_ALU_SAT_EN for signed saturating arithmetic.
package simd_pkg;

   localparam int unsigned DEF_LANES  = 10;
   localparam int unsigned DEF_LANE_W = 16;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_MAC = 2'b11
   } opcode_t;

endpackage

// File: rtl/simd_lane.sv
// One lane: ALU, optional saturation, accumulator and S2 result register.
// Build option: SIMD_VEC_ALU_SAT_EN selects signed saturation instead of wrap.
module simd_lane
   import simd_pkg::*;
#(
   parameter int unsigned LANE_W = DEF_LANE_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en_i,
   input  opcode_t           op_i,
   input  logic              clr_i,
   input  logic [LANE_W-1:0] a_i,
   input  logic [LANE_W-1:0] b_i,
   output logic [LANE_W-1:0] res_o
);

`ifdef SIMD_VEC_ALU_SAT_EN
   // Wide enough to hold acc + A*B exactly before clamping.
   localparam int unsigned PW = 2*LANE_W + 1;
   localparam logic signed [PW-1:0] SMAX = {{(PW-LANE_W+1){1'b0}}, {(LANE_W-1){1'b1}}};
   localparam logic signed [PW-1:0] SMIN = ~SMAX;
`else
   localparam int unsigned PW = LANE_W;
`endif

   logic [LANE_W-1:0]        acc_q;
   logic [LANE_W-1:0]        res_q;
   logic [LANE_W-1:0]        res_d;
   logic signed [PW-1:0]     a_x;
   logic signed [PW-1:0]     b_x;
   logic signed [PW-1:0]     base_x;
   logic signed [PW-1:0]     prod_x;
   logic signed [PW-1:0]     sum_x;

   // Lane arithmetic, then clamp or truncate to LANE_W.
   always_comb begin
      a_x    = PW'($signed(a_i));
      b_x    = PW'($signed(b_i));
      base_x = clr_i ? '0 : PW'($signed(acc_q));
      prod_x = a_x * b_x;
      case (op_i)
         OP_ADD:  sum_x = a_x + b_x;
         OP_SUB:  sum_x = a_x - b_x;
         OP_MUL:  sum_x = prod_x;
         default: sum_x = base_x + prod_x;
      endcase
`ifdef SIMD_VEC_ALU_SAT_EN
      if (sum_x > SMAX)       res_d = SMAX[LANE_W-1:0];
      else if (sum_x < SMIN)  res_d = SMIN[LANE_W-1:0];
      else                    res_d = sum_x[LANE_W-1:0];
`else
      res_d = sum_x[LANE_W-1:0];
`endif
   end

   // Result and accumulator load only when a valid beat moves S1 -> S2.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res_q <= '0;
         acc_q <= '0;
      end else if (en_i) begin
         res_q <= res_d;
         if (op_i == OP_MAC) acc_q <= res_d;
      end
   end

   assign res_o = res_q;

endmodule

// File: rtl/simd_vec_alu.sv
// Two-stage SIMD vector ALU with valid/ready handshake; the pipe stalls as a unit.
// Build option: SIMD_VEC_ALU_SAT_EN selects signed saturating lanes.
module simd_vec_alu
   import simd_pkg::*;
#(
   parameter int unsigned LANES  = DEF_LANES,
   parameter int unsigned LANE_W = DEF_LANE_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*LANE_W-1:0] in_a,
   input  logic [LANES*LANE_W-1:0] in_b,
   input  logic [1:0]              opcode,
   input  logic                    acc_clr,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*LANE_W-1:0] out_data
);

   localparam int unsigned VW = LANES*LANE_W;

   logic          s1_v_q, s1_v_d;
   logic          s2_v_q, s2_v_d;
   logic          stall_c;
   logic          lane_en_c;
   logic [VW-1:0] a_q;
   logic [VW-1:0] b_q;
   opcode_t       op_q;
   logic          clr_q;

   // Shared stall and valid-flag advance.
   always_comb begin
      stall_c   = s2_v_q && !out_ready;
      s1_v_d    = s1_v_q;
      s2_v_d    = s2_v_q;
      if (!stall_c) begin
         s2_v_d = s1_v_q;
         s1_v_d = in_valid;
      end
      lane_en_c = !stall_c && s1_v_q;
   end

   assign in_ready  = rst_n && !stall_c;
   assign out_valid = s2_v_q;

   // S1 operand capture and valid flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_v_q <= 1'b0;
         s2_v_q <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= OP_ADD;
         clr_q  <= 1'b0;
      end else begin
         s1_v_q <= s1_v_d;
         s2_v_q <= s2_v_d;
         if (!stall_c && in_valid) begin
            a_q   <= in_a;
            b_q   <= in_b;
            op_q  <= opcode_t'(opcode);
            clr_q <= acc_clr;
         end
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      simd_lane #(.LANE_W(LANE_W)) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .en_i  (lane_en_c),
         .op_i  (op_q),
         .clr_i (clr_q),
         .a_i   (a_q[k*LANE_W +: LANE_W]),
         .b_i   (b_q[k*LANE_W +: LANE_W]),
         .res_o (out_data[k*LANE_W +: LANE_W])
      );
   end

endmodule
